// File: rtl/uart_axi_debug.sv
// rtl/uart_axi_debug.sv - UART byte-stream to AXI-lite single-beat read/write debug bridge
// Optional inter-byte rx timeout enabled by defining UART_AXI_DBG_TIMEOUT_EN.
module uart_axi_debug #(
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        uart_rx,
    input  logic              uart_rx_valid,
    output logic              uart_rx_ready,
    output logic [7:0]        uart_tx,
    output logic              uart_tx_valid,
    input  logic              uart_tx_ready,
    output logic [ADDR_W-1:0] axi_ar_addr,
    output logic              axi_ar_valid,
    input  logic              axi_ar_ready,
    input  logic [DATA_W-1:0] axi_r_data,
    input  logic [1:0]        axi_r_resp,
    input  logic              axi_r_valid,
    output logic              axi_r_ready,
    output logic [ADDR_W-1:0] axi_aw_addr,
    output logic              axi_aw_valid,
    input  logic              axi_aw_ready,
    output logic [DATA_W-1:0] axi_w_data,
    output logic [DATA_W/8-1:0] axi_w_strb,
    output logic              axi_w_valid,
    input  logic              axi_w_ready,
    input  logic [1:0]        axi_b_resp,
    input  logic              axi_b_valid,
    output logic              axi_b_ready
);
    localparam int AB  = (ADDR_W + 7) / 8;
    localparam int DB  = DATA_W / 8;
    localparam int AW8 = AB * 8;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_AR, S_R, S_AWW, S_B, S_TX
    } state_t;

    state_t            state, state_nx;
    logic              is_write;
    logic [2:0]        byte_cnt;
    logic [2:0]        tx_idx;
    logic [AW8-1:0]    addr_sh;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        resp;
    logic              aw_done, w_done;
    logic              take, tmo, tx_last;
    logic [7:0]        tx_byte;

    assign take    = uart_rx_valid && uart_rx_ready;
    assign tx_last = is_write ? (tx_idx == 3'd0) : (tx_idx == 3'(DB));

`ifdef UART_AXI_DBG_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || take || !(state == S_ADDR || state == S_WDATA)) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    // A byte arriving on the expiry cycle still wins over the timeout.
    assign tmo = (tmo_cnt >= 32'(TIMEOUT_CYCLES)) && !take;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign tmo        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (take && (uart_rx == 8'h52 || uart_rx == 8'h57)) state_nx = S_ADDR;
            S_ADDR: begin
                if (tmo) begin
                    state_nx = S_IDLE;
                end else if (take && byte_cnt == 3'(AB - 1)) begin
                    state_nx = is_write ? S_WDATA : S_AR;
                end
            end
            S_WDATA: begin
                if (tmo) begin
                    state_nx = S_IDLE;
                end else if (take && byte_cnt == 3'(DB - 1)) begin
                    state_nx = S_AWW;
                end
            end
            S_AR:    if (axi_ar_ready) state_nx = S_R;
            S_R:     if (axi_r_valid) state_nx = S_TX;
            S_AWW:   if ((aw_done || axi_aw_ready) && (w_done || axi_w_ready)) state_nx = S_B;
            S_B:     if (axi_b_valid) state_nx = S_TX;
            S_TX:    if (uart_tx_ready && tx_last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_write <= 1'b0;
            byte_cnt <= '0;
            tx_idx   <= '0;
            addr_sh  <= '0;
            wdata_sh <= '0;
            rdata    <= '0;
            resp     <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        is_write <= (uart_rx == 8'h57);
                        byte_cnt <= '0;
                        tx_idx   <= '0;
                        addr_sh  <= '0;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (take) begin
                        addr_sh  <= (addr_sh << 8) | AW8'(uart_rx);
                        byte_cnt <= (byte_cnt == 3'(AB - 1)) ? 3'd0 : byte_cnt + 3'd1;
                    end
                end
                S_WDATA: begin
                    if (take) begin
                        wdata_sh <= (wdata_sh << 8) | DATA_W'(uart_rx);
                        byte_cnt <= byte_cnt + 3'd1;
                    end
                end
                S_R: begin
                    if (axi_r_valid) begin
                        rdata <= axi_r_data;
                        resp  <= axi_r_resp;
                    end
                end
                S_AWW: begin
                    if (axi_aw_ready) aw_done <= 1'b1;
                    if (axi_w_ready)  w_done  <= 1'b1;
                end
                S_B:  if (axi_b_valid) resp <= axi_b_resp;
                S_TX: if (uart_tx_ready) tx_idx <= tx_idx + 3'd1;
                default: ;
            endcase
        end
    end

    // Byte 0 is the status; bytes 1..DB are read data, MSB first.
    always_comb begin
        tx_byte = (resp == 2'b00) ? 8'h06 : 8'h15;
        for (int i = 0; i < DB; i++) begin
            if (int'(tx_idx) == i + 1) tx_byte = rdata[DATA_W-1-8*i -: 8];
        end
    end

    always_comb begin
        uart_rx_ready = (state == S_IDLE) || (state == S_ADDR) || (state == S_WDATA);
        uart_tx_valid = (state == S_TX);
        uart_tx       = (state == S_TX) ? tx_byte : 8'h00;
        axi_ar_valid  = (state == S_AR);
        axi_r_ready   = (state == S_R);
        axi_aw_valid  = (state == S_AWW) && !aw_done;
        axi_w_valid   = (state == S_AWW) && !w_done;
        axi_b_ready   = (state == S_B);
        axi_ar_addr   = addr_sh[ADDR_W-1:0];
        axi_aw_addr   = addr_sh[ADDR_W-1:0];
        axi_w_data    = wdata_sh;
        axi_w_strb    = '1;
    end
endmodule
